// File: rtl/io_bridge.sv
// io_bridge: CPU byte-bus I/O window decoder with TX FIFO, RX hand-off,
// cycle counter snapshot, program-stop flag and RAM/I/O read-data mux.
//
// Ports:
//   clk, rst (async, active-low)  rdy  : CPU ready, low freezes CPU-side state
//   cpu_a/cpu_dout/cpu_wr/cpu_din      : CPU byte bus, read data 1 cycle late
//   io_buffer_full                     : TX FIFO nearly full (registered)
//   ram_din                            : RAM read data (already 1 cycle late)
//   rx_valid/rx_data/rx_ready          : RX byte source, rx_ready pops
//   tx_valid/tx_data/tx_ready          : TX byte sink (FIFO head)
//   prog_stop, tx_overflow             : sticky status flags
module io_bridge #(
    parameter int TX_DEPTH_LOG2 = 3,
    parameter int FULL_MARGIN   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [31:0] cpu_a,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_wr,
    output logic [7:0]  cpu_din,
    output logic        io_buffer_full,
    input  logic [7:0]  ram_din,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        prog_stop,
    output logic        tx_overflow
);

    localparam int DEPTH = 1 << TX_DEPTH_LOG2;
    localparam int PW    = TX_DEPTH_LOG2;
    localparam int CW    = TX_DEPTH_LOG2 + 1;

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH - FULL_MARGIN);

    logic [7:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_full;
    logic          r_stop;
    logic          r_ovf;
    logic [31:0]   r_cycle_cnt;
    logic [31:0]   r_cnt_snap;
    logic          r_sel_io;
    logic [7:0]    r_io_rdata;

    logic          w_io;
    logic          w_io_wr;
    logic          w_io_rd;
    logic          w_any_rd;
    logic [2:0]    w_sel;
    logic          w_push;
    logic [7:0]    w_push_data;
    logic          w_stop_wr;
    logic          w_rx_take;
    logic [7:0]    w_rd_data;
    logic          w_pop;
    logic          w_fifo_full;
    logic          w_push_ok;
    logic          w_drop;
    logic [CW-1:0] w_count_nxt;
    logic          w_unused;

    assign w_unused = &{1'b0, cpu_a[31:18], cpu_a[15:3]};

    assign w_io     = (cpu_a[17:16] == 2'b11);
    assign w_sel    = cpu_a[2:0];
    assign w_io_wr  = rdy & w_io & cpu_wr;
    assign w_io_rd  = rdy & w_io & ~cpu_wr;
    assign w_any_rd = rdy & ~cpu_wr;

    // Write decode: 0x00 written to the data port is a no-op, while the
    // stop port always enqueues a terminating 0x00.
    always_comb begin
        w_push      = 1'b0;
        w_push_data = cpu_dout;
        w_stop_wr   = 1'b0;
        if (w_io_wr) begin
            if (w_sel == 3'd0) begin
                w_push = (cpu_dout != 8'h00);
            end else if (w_sel == 3'd4) begin
                w_push      = 1'b1;
                w_push_data = 8'h00;
                w_stop_wr   = 1'b1;
            end
        end
    end

    // Read decode: bytes 1-3 come from the snapshot taken by the byte-0
    // read so a 4-byte counter read is coherent.
    always_comb begin
        w_rx_take = 1'b0;
        w_rd_data = 8'h00;
        case (w_sel)
            3'd0: begin
                if (rx_valid) begin
                    w_rx_take = 1'b1;
                    w_rd_data = rx_data;
                end
            end
            3'd4:    w_rd_data = r_cycle_cnt[7:0];
            3'd5:    w_rd_data = r_cnt_snap[15:8];
            3'd6:    w_rd_data = r_cnt_snap[23:16];
            3'd7:    w_rd_data = r_cnt_snap[31:24];
            default: w_rd_data = 8'h00;
        endcase
    end

    assign rx_ready = w_io_rd & w_rx_take;

    // A full FIFO still accepts a push when the head leaves the same cycle.
    assign w_pop       = (r_count != '0) & tx_ready;
    assign w_fifo_full = (r_count == DEPTH_C);
    assign w_push_ok   = w_push & (~w_fifo_full | w_pop);
    assign w_drop      = w_push & w_fifo_full & ~w_pop;
    assign w_count_nxt = r_count
                       + {{(CW-1){1'b0}}, w_push_ok}
                       - {{(CW-1){1'b0}}, w_pop};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 8'h00;
            end
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_full      <= 1'b0;
            r_stop      <= 1'b0;
            r_ovf       <= 1'b0;
            r_cycle_cnt <= 32'h0;
            r_cnt_snap  <= 32'h0;
            r_sel_io    <= 1'b0;
            r_io_rdata  <= 8'h00;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= w_push_data;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt >= FULL_LVL);
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
            if (w_stop_wr) begin
                r_stop <= 1'b1;
            end
            if (rdy) begin
                r_cycle_cnt <= r_cycle_cnt + 32'd1;
            end
            if (w_io_rd && (w_sel == 3'd4)) begin
                r_cnt_snap <= r_cycle_cnt;
            end
            if (w_any_rd) begin
                r_sel_io <= w_io;
                if (w_io) begin
                    r_io_rdata <= w_rd_data;
                end
            end
        end
    end

    assign tx_valid       = (r_count != '0);
    assign tx_data        = r_mem[r_rd_ptr];
    assign io_buffer_full = r_full;
    assign prog_stop      = r_stop;
    assign tx_overflow    = r_ovf;
    assign cpu_din        = r_sel_io ? r_io_rdata : ram_din;

endmodule

// File: tb/tb_io_bridge.sv
// tb_io_bridge: directed and randomized checks of io_bridge against a
// queue-based behavioural model of the I/O window.
module tb_io_bridge;

    localparam int DEPTH = 8;
    localparam int THR   = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b0;
    logic [31:0] cpu_a = 32'h0;
    logic [7:0]  cpu_dout = 8'h0;
    logic        cpu_wr = 1'b0;
    logic [7:0]  cpu_din;
    logic        io_buffer_full;
    logic [7:0]  ram_din = 8'h0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h0;
    logic        rx_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b0;
    logic        prog_stop;
    logic        tx_overflow;

    io_bridge #(.TX_DEPTH_LOG2(3), .FULL_MARGIN(2)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .cpu_a(cpu_a), .cpu_dout(cpu_dout), .cpu_wr(cpu_wr),
        .cpu_din(cpu_din), .io_buffer_full(io_buffer_full),
        .ram_din(ram_din), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(tx_ready), .prog_stop(prog_stop),
        .tx_overflow(tx_overflow)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0]  q[$];
    logic        m_stop, m_ovf, m_sel;
    logic [7:0]  m_io;
    logic [31:0] m_cnt, m_snap;

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_stop = 1'b0;
        m_ovf  = 1'b0;
        m_sel  = 1'b0;
        m_io   = 8'h00;
        m_cnt  = 32'h0;
        m_snap = 32'h0;
    endtask

    // Checks all outputs against the model, then advances the model by
    // the clock edge that ends this cycle. Called right after a negedge.
    task automatic step();
        logic       io, pop, pushv, was_full;
        logic [7:0] pb;
        #1;
        io = (cpu_a[17:16] == 2'b11);
        chk("rx_ready", 32'(rx_ready),
            32'(rdy && io && !cpu_wr && cpu_a[2:0] == 3'd0 && rx_valid));
        chk("tx_valid", 32'(tx_valid), 32'(q.size() != 0));
        if (q.size() != 0) chk("tx_data", 32'(tx_data), 32'(q[0]));
        chk("io_buffer_full", 32'(io_buffer_full), 32'(q.size() >= THR));
        chk("prog_stop", 32'(prog_stop), 32'(m_stop));
        chk("tx_overflow", 32'(tx_overflow), 32'(m_ovf));
        chk("cpu_din", 32'(cpu_din), 32'(m_sel ? m_io : ram_din));

        pop   = (q.size() != 0) && tx_ready;
        pushv = 1'b0;
        pb    = 8'h00;
        if (rdy && io && cpu_wr) begin
            if (cpu_a[2:0] == 3'd0 && cpu_dout != 8'h00) begin
                pushv = 1'b1;
                pb    = cpu_dout;
            end else if (cpu_a[2:0] == 3'd4) begin
                pushv  = 1'b1;
                m_stop = 1'b1;
            end
        end
        was_full = (q.size() == DEPTH);
        if (pop) void'(q.pop_front());
        if (pushv) begin
            if (was_full && !pop) m_ovf = 1'b1;
            else q.push_back(pb);
        end
        if (rdy && !cpu_wr) begin
            m_sel = io;
            if (io) begin
                case (cpu_a[2:0])
                    3'd0: m_io = rx_valid ? rx_data : 8'h00;
                    3'd4: begin
                        m_io   = m_cnt[7:0];
                        m_snap = m_cnt;
                    end
                    3'd5: m_io = m_snap[15:8];
                    3'd6: m_io = m_snap[23:16];
                    3'd7: m_io = m_snap[31:24];
                    default: m_io = 8'h00;
                endcase
            end
        end
        if (rdy) m_cnt = m_cnt + 32'd1;
        @(negedge clk);
    endtask

    task automatic setin(logic r, logic [31:0] a, logic w, logic [7:0] d);
        rdy = r;
        cpu_a = a;
        cpu_wr = w;
        cpu_dout = d;
    endtask

    task automatic drive(logic r, logic [31:0] a, logic w, logic [7:0] d);
        setin(r, a, w, d);
        step();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        setin(1'b0, 32'h0, 1'b0, 8'h00);
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        ram_din = 8'h5A;
        model_reset();
        #1;
        chk("rst tx_valid", 32'(tx_valid), 32'h0);
        chk("rst tx_data", 32'(tx_data), 32'h0);
        chk("rst io_buffer_full", 32'(io_buffer_full), 32'h0);
        chk("rst prog_stop", 32'(prog_stop), 32'h0);
        chk("rst tx_overflow", 32'(tx_overflow), 32'h0);
        chk("rst rx_ready", 32'(rx_ready), 32'h0);
        chk("rst cpu_din", 32'(cpu_din), 32'h5A);
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [31:0] r32, a;
        int p;

        @(negedge clk);
        do_reset();

        // RAM read passes ram_din through
        drive(1'b1, 32'h100, 1'b0, 8'h00);
        ram_din = 8'hA5;
        #1 chk("ram read", 32'(cpu_din), 32'hA5);
        drive(1'b0, 32'h0, 1'b0, 8'h00);

        // 0x00 writes are ignored
        drive(1'b1, 32'h30000, 1'b1, 8'h41);
        drive(1'b1, 32'h30000, 1'b1, 8'h00);
        drive(1'b1, 32'h30000, 1'b1, 8'h42);
        setin(1'b0, 32'h0, 1'b0, 8'h00);
        #1;
        chk("fifo head", 32'(tx_data), 32'h41);
        chk("model count", q.size(), 32'd2);
        tx_ready = 1'b1;
        step();
        #1 chk("second byte", 32'(tx_data), 32'h42);
        step();
        #1 chk("drained", 32'(tx_valid), 32'h0);

        // fill, threshold and overflow
        tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 32'h30000, 1'b1, 8'(8'h11 + i));
            #1;
            if (i == 4) chk("full@5", 32'(io_buffer_full), 32'h0);
            if (i == 5) chk("full@6", 32'(io_buffer_full), 32'h1);
            if (i == 7) chk("ovf@8", 32'(tx_overflow), 32'h0);
            if (i == 8) chk("ovf@9", 32'(tx_overflow), 32'h1);
        end
        chk("model full", q.size(), 32'd8);
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) drive(1'b0, 32'h30000, 1'b1, 8'h77);
        #1 chk("drain no rdy", 32'(tx_valid), 32'h0);
        tx_ready = 1'b0;

        // RX hand-off
        rx_valid = 1'b1;
        rx_data = 8'h37;
        setin(1'b1, 32'h30000, 1'b0, 8'h00);
        #1 chk("rx pulse", 32'(rx_ready), 32'h1);
        step();
        rx_valid = 1'b0;
        #1 chk("rx data", 32'(cpu_din), 32'h37);
        setin(1'b1, 32'h30000, 1'b0, 8'h00);
        #1 chk("rx no pulse", 32'(rx_ready), 32'h0);
        step();
        #1 chk("rx empty", 32'(cpu_din), 32'h00);

        // counter snapshot
        do_reset();
        for (int i = 0; i < 32'h1234; i++) drive(1'b1, 32'h200, 1'b0, 8'h00);
        chk("model cnt", m_cnt, 32'h1234);
        drive(1'b1, 32'h30004, 1'b0, 8'h00);
        #1 chk("cnt b0", 32'(cpu_din), 32'h34);
        drive(1'b1, 32'h30005, 1'b0, 8'h00);
        #1 chk("cnt b1", 32'(cpu_din), 32'h12);
        drive(1'b1, 32'h30006, 1'b0, 8'h00);
        #1 chk("cnt b2", 32'(cpu_din), 32'h00);
        drive(1'b1, 32'h30007, 1'b0, 8'h00);
        #1 chk("cnt b3", 32'(cpu_din), 32'h00);

        // prog_stop and reset mid-drain
        drive(1'b1, 32'h30000, 1'b1, 8'h55);
        drive(1'b1, 32'h30004, 1'b1, 8'h99);
        #1;
        chk("stop set", 32'(prog_stop), 32'h1);
        chk("stop count", q.size(), 32'd2);
        tx_ready = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 8'h00);
        #1 chk("stop byte", 32'(tx_data), 32'h00);
        #1 rst = 1'b0;
        #1;
        chk("async stop", 32'(prog_stop), 32'h0);
        chk("async empty", 32'(tx_valid), 32'h0);
        @(negedge clk);
        model_reset();
        rst = 1'b1;

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            if (i % 64 == 0) p = $urandom_range(0, 4);
            r32 = $urandom();
            a = $urandom();
            if (r32[0]) begin
                a[17:16] = 2'b11;
                if (r32[1]) a[2] = 1'b1;
            end else if (a[17:16] == 2'b11) begin
                a[17] = 1'b0;
            end
            rdy = ($urandom_range(0, 7) != 0);
            cpu_a = a;
            cpu_wr = r32[4];
            cpu_dout = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom());
            ram_din = 8'($urandom());
            rx_valid = r32[5];
            rx_data = 8'($urandom());
            tx_ready = ($urandom_range(0, 3) < p);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
